// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive sequencer: state encoding,
// legal oversampling ratios and the default frame data width.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_t;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam int DEF_DATA_WIDTH = 8;

  function automatic logic is_legal_prescale(input int unsigned presc);
    return (presc == PRESC_8) || (presc == PRESC_16) || (presc == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_slot_decode.sv
// Bit-slot timing compares against the edge counter: sample window around
// mid-bit, check point, bit end and the early stop-bit exit.
module uart_rx_slot_decode #(
  parameter int PRESC_W = 6
) (
  input  logic [PRESC_W-1:0] presc,
  input  logic [PRESC_W-1:0] edge_cnt,
  output logic               samp_win,
  output logic               chk_pt,
  output logic               bit_end,
  output logic               stop_exit
);

  logic [PRESC_W-1:0] mid;

  // All offsets stay at PRESC_W bits; mid+3 is at most 19 for the largest ratio.
  assign mid       = presc >> 1;
  assign samp_win  = (edge_cnt == mid - PRESC_W'(1)) ||
                     (edge_cnt == mid) ||
                     (edge_cnt == mid + PRESC_W'(1));
  assign chk_pt    = (edge_cnt == mid + PRESC_W'(2));
  assign bit_end   = (edge_cnt == presc);
  assign stop_exit = (edge_cnt == mid + PRESC_W'(3));

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: walks start/data/parity/stop slots, strobes the
// sampler, deserialiser and checkers, and qualifies each received byte.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESC_W    = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [PRESC_W-1:0]   Prescale,
  input  logic                 par_en,
  input  logic [PRESC_W-1:0]   edge_cnt,
  input  logic [BIT_CNT_W-1:0] bit_cnt,
  input  logic                 strt_glitch,
  input  logic                 par_err,
  input  logic                 stp_err,
  output logic                 cnt_en,
  output logic                 samp_en,
  output logic                 deser_en,
  output logic                 strt_chk_en,
  output logic                 par_chk_en,
  output logic                 stp_chk_en,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  rx_state_t          state;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q;
  logic               par_flag;
  logic               stp_flag;

  logic samp_win;
  logic chk_pt;
  logic bit_end;
  logic stop_exit;
  logic last_data;
  logic in_frame;

  // Timing uses the ratio captured at frame start, so mid-frame changes are ignored.
  uart_rx_slot_decode #(
    .PRESC_W (PRESC_W)
  ) u_slot_decode (
    .presc     (presc_q),
    .edge_cnt  (edge_cnt),
    .samp_win  (samp_win),
    .chk_pt    (chk_pt),
    .bit_end   (bit_end),
    .stop_exit (stop_exit)
  );

  assign last_data = bit_end && (bit_cnt == BIT_CNT_W'(DATA_WIDTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc_q  <= '0;
      par_en_q <= 1'b0;
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_in && is_legal_prescale(32'(Prescale))) begin
            state    <= START;
            presc_q  <= Prescale;
            par_en_q <= par_en;
          end
        end
        START: begin
          if (bit_end) state <= strt_glitch ? IDLE : DATA;
        end
        DATA: begin
          if (last_data) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (bit_end) begin
            par_flag <= par_err;
            state    <= STOP;
          end
        end
        STOP: begin
          // Leaving half a bit early lets a back-to-back start edge be caught.
          if (stop_exit) begin
            stp_flag <= stp_err;
            state    <= DONE;
          end
        end
        DONE: begin
          par_flag <= 1'b0;
          stp_flag <= 1'b0;
          state    <= rx_in ? IDLE : START;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_frame = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);

  // NOTE: every output gets a default before the case, otherwise the
  // uncovered states would infer latches.
  always_comb begin
    cnt_en      = 1'b0;
    samp_en     = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;
    parity_err  = 1'b0;

    cnt_en  = in_frame;
    samp_en = in_frame && samp_win;

    case (state)
      START:  strt_chk_en = chk_pt;
      DATA:   deser_en    = chk_pt;
      PARITY: par_chk_en  = chk_pt;
      STOP:   stp_chk_en  = chk_pt;
      DONE: begin
        frame_err  = stp_flag;
        parity_err = !stp_flag && par_flag;
        data_valid = !stp_flag && !par_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter and
// per-frame pulse bookkeeping compared against hand-computed counts.
module tb_uart_rx_fsm;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] Prescale;
  logic       par_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, frame_err, parity_err;

  uart_rx_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .Prescale    (Prescale),
    .par_en      (par_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .cnt_en      (cnt_en),
    .samp_en     (samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment model of the edge/bit counter driven by cnt_en.
  always @(posedge clk) begin
    if (rst || !cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == Prescale) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  int n_cnt, n_samp, n_deser, n_strt, n_par, n_stp, n_dv, n_fe, n_pe;
  int deser_min, deser_max, strt_edge, par_edge, stp_edge;
  int dv_next_cnt;
  bit prev_dv, dv_next_seen;
  bit start_req, glitch_mode;
  int b2b_left, low_cycles;
  logic frame_bits [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_cnt = 0; n_samp = 0; n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0;
    n_dv = 0; n_fe = 0; n_pe = 0;
    deser_min = 99; deser_max = -1; strt_edge = -1; par_edge = -1; stp_edge = -1;
    dv_next_cnt = -1; prev_dv = 0; dv_next_seen = 0; low_cycles = 0;
  endtask

  // One clock: sample outputs on the falling edge, then drive rx_in.
  task automatic tick();
    @(negedge clk);
    if (cnt_en)      n_cnt++;
    if (samp_en)     n_samp++;
    if (deser_en) begin
      n_deser++;
      if (int'(edge_cnt) < deser_min) deser_min = int'(edge_cnt);
      if (int'(edge_cnt) > deser_max) deser_max = int'(edge_cnt);
    end
    if (strt_chk_en) begin n_strt++; strt_edge = int'(edge_cnt); end
    if (par_chk_en)  begin n_par++;  par_edge  = int'(edge_cnt); end
    if (stp_chk_en)  begin n_stp++;  stp_edge  = int'(edge_cnt); end
    if (data_valid)  n_dv++;
    if (frame_err)   n_fe++;
    if (parity_err)  n_pe++;
    if (prev_dv && !dv_next_seen) begin
      dv_next_cnt  = int'(cnt_en);
      dv_next_seen = 1;
    end
    prev_dv = data_valid;

    if (cnt_en) begin
      start_req = 0;
      low_cycles++;
    end
    if ((data_valid || frame_err || parity_err) && b2b_left > 0) begin
      b2b_left--;
      start_req = 1;
    end
    if (start_req)    rx_in = 1'b0;
    else if (cnt_en)  rx_in = glitch_mode ? (low_cycles >= 4) : frame_bits[bit_cnt];
    else              rx_in = 1'b1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic setup_frame(input int presc, input bit pen, input logic [7:0] d,
                             input bit par_bit);
    Prescale = 6'(presc);
    par_en   = pen;
    for (int i = 0; i < 16; i++) frame_bits[i] = 1'b1;
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame_bits[i+1] = d[i];
    if (pen) frame_bits[9] = par_bit;
    clear_mon();
    start_req = 1;
    rx_in     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; Prescale = 6'd8; par_en = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    start_req = 0; glitch_mode = 0; b2b_left = 0;
    for (int i = 0; i < 16; i++) frame_bits[i] = 1'b1;
    clear_mon();
    run(3);
    check("reset_outputs",
          {23'd0, cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
           data_valid, frame_err, parity_err}, 32'd0);
    rst = 1'b0;
    run(2);
    check("idle_cnt_en", {31'd0, cnt_en}, 32'd0);

    // Prescale 8, no parity, 0x5A, good stop
    setup_frame(8, 1'b0, 8'h5A, 1'b0);
    run(120);
    check("p8_deser_cnt", n_deser, 8);
    check("p8_deser_min", deser_min, 6);
    check("p8_deser_max", deser_max, 6);
    check("p8_strt_edge", strt_edge, 6);
    check("p8_stp_edge",  stp_edge, 6);
    check("p8_samp_cnt",  n_samp, 30);
    check("p8_cnt_cycles", n_cnt, 89);
    check("p8_data_valid", n_dv, 1);
    check("p8_errors", n_fe + n_pe + n_par, 0);

    // Prescale 16, parity enabled, bad parity reported
    par_err = 1'b1;
    setup_frame(16, 1'b1, 8'hC3, 1'b0);
    run(230);
    par_err = 1'b0;
    check("p16_par_cnt", n_par, 1);
    check("p16_par_edge", par_edge, 10);
    check("p16_deser_edge", deser_min, 10);
    check("p16_cnt_cycles", n_cnt, 182);
    check("p16_parity_err", n_pe, 1);
    check("p16_data_valid", n_dv, 0);
    check("p16_frame_err", n_fe, 0);

    // Start glitch: short low pulse, checker flags it
    strt_glitch = 1'b1;
    glitch_mode = 1;
    setup_frame(16, 1'b0, 8'hFF, 1'b0);
    run(60);
    strt_glitch = 1'b0;
    glitch_mode = 0;
    check("glitch_strt_cnt", n_strt, 1);
    check("glitch_cnt_cycles", n_cnt, 17);
    check("glitch_deser", n_deser, 0);
    check("glitch_pulses", n_dv + n_fe + n_pe, 0);
    check("glitch_cnt_en_low", {31'd0, cnt_en}, 32'd0);

    // Prescale 32, stop error
    stp_err = 1'b1;
    setup_frame(32, 1'b0, 8'h81, 1'b0);
    run(360);
    stp_err = 1'b0;
    check("p32_stp_edge", stp_edge, 18);
    check("p32_cnt_cycles", n_cnt, 317);
    check("p32_frame_err", n_fe, 1);
    check("p32_data_valid", n_dv, 0);
    check("p32_parity_err", n_pe, 0);

    // Back-to-back frames at Prescale 8
    setup_frame(8, 1'b0, 8'h3C, 1'b0);
    b2b_left = 1;
    run(230);
    check("b2b_data_valid", n_dv, 2);
    check("b2b_deser", n_deser, 16);
    check("b2b_no_idle_gap", dv_next_cnt, 1);
    check("b2b_cnt_cycles", n_cnt, 178);

    // Illegal Prescale holds IDLE
    setup_frame(12, 1'b0, 8'h00, 1'b0);
    run(150);
    start_req = 0;
    check("p12_cnt_cycles", n_cnt, 0);
    check("p12_strobes", n_samp + n_strt + n_deser + n_stp, 0);
    check("p12_pulses", n_dv + n_fe + n_pe, 0);
    Prescale = 6'd8;
    run(3);

    // Reset in the middle of DATA
    setup_frame(8, 1'b0, 8'hA5, 1'b0);
    begin
      int waited = 0;
      while (!(cnt_en && bit_cnt == 4'd3) && waited < 200) begin
        tick();
        waited++;
      end
      check("rst_reach_data", {31'd0, (cnt_en && bit_cnt == 4'd3)}, 32'd1);
    end
    rst = 1'b1;
    start_req = 0;
    tick();
    check("rst_outputs",
          {23'd0, cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
           data_valid, frame_err, parity_err}, 32'd0);
    rst = 1'b0;
    clear_mon();
    run(120);
    check("rst_no_dv", n_dv, 0);
    check("rst_no_deser", n_deser, 0);
    check("rst_stays_idle", n_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
